// File: rtl/lif_pkg.sv
// Shared definitions for the LIF accelerator core: scan command encoding,
// datapath widths and the fixed network parameters.
package lif_pkg;

    // Scan command bus encoding; any 1xx value behaves as idle.
    typedef enum logic [2:0] {
        CMD_IDLE  = 3'b000,
        CMD_RUN   = 3'b001,
        CMD_PAUSE = 3'b010,
        CMD_RST   = 3'b011
    } lif_cmd_e;

    localparam int NEURONS       = 256;
    localparam int IDX_W         = 8;
    localparam int DATA_W        = 16;
    localparam int COEF_W        = 16;
    localparam int SUM_W         = DATA_W + 2;
    localparam int WORD_W        = 4;
    localparam int PRESYN_PERIOD = 4;
    localparam int WEIGHT        = 16;
    localparam int THRESHOLD     = 1024;
    localparam int LEAK_SHIFT    = 4;
    localparam int FIFO_DEPTH    = 64;
    localparam int FIFO_AW       = 6;

    // Presynaptic neuron idx is an active input spike on a fixed period.
    function automatic logic is_input_spike(input logic [IDX_W-1:0] idx);
        return (idx % IDX_W'(PRESYN_PERIOD)) == '0;
    endfunction

endpackage

// File: rtl/lif_scan_counter.sv
// Command-driven neuron index counter shared by the presyn and postsyn scans.
// Advances once per RUN cycle, parks at the last index with done set.
module lif_scan_counter
    import lif_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [2:0]       cmd,
    input  logic             stall,
    output logic [IDX_W-1:0] num,
    output logic             done,
    output logic             advance
);

    assign advance = (cmd == CMD_RUN) && !done && !stall;

    // Index/done state: reset command wins over run; last advance sets done and holds the index.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            num  <= '0;
            done <= 1'b0;
        end else if (cmd == CMD_RST) begin
            num  <= '0;
            done <= 1'b0;
        end else if (advance) begin
            if (num == IDX_W'(NEURONS - 1)) begin
                done <= 1'b1;
            end else begin
                num <= num + 1'b1;
            end
        end
    end

endmodule

// File: rtl/neuromorphic_design.sv
// Leaky-integrate-and-fire core: presyn scan accumulates a shared synaptic
// current, postsyn scan updates 256 membranes and queues 4-bit spike words
// into a first-word-fall-through FIFO.
// Optional build macro: LIF_LEAK_EN (enables V >> LEAK_SHIFT membrane leak).
module neuromorphic_design
    import lif_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [2:0]        presyn_cntl_sig,
    input  logic [2:0]        postsyn_cntl_sig,
    input  logic              dbg_sig_rd_fifo,
    output logic              fifo_output_genfifo_req_o,
    output logic [WORD_W-1:0] fifo_output_genfifo_wdata_bo [0:0]
);

    // Current accumulation saturates instead of wrapping.
    function automatic logic [DATA_W-1:0] sat_add_current(input logic [DATA_W-1:0] a,
                                                          input logic [COEF_W-1:0] b);
        logic [DATA_W:0] s;
        s = {1'b0, a} + {{(DATA_W - COEF_W + 1){1'b0}}, b};
        return s[DATA_W] ? {DATA_W{1'b1}} : s[DATA_W-1:0];
    endfunction

    // Clamp the widened membrane sum back into the unsigned membrane range.
    function automatic logic [DATA_W-1:0] sat_membrane(input logic [SUM_W-1:0] s);
        return (s[SUM_W-1:DATA_W] != '0) ? {DATA_W{1'b1}} : s[DATA_W-1:0];
    endfunction

    logic [IDX_W-1:0]  presyn_neuron_counter_num;
    logic              presyn_counter_done;
    logic              presyn_advance;
    logic [IDX_W-1:0]  postsyn_neuron_counter_num;
    logic              postsyn_counter_done;
    logic              postsyn_advance;
    logic              postsyn_stall;

    logic [DATA_W-1:0] syn_current;
    logic [DATA_W-1:0] membrane [NEURONS];
    logic [WORD_W-1:0] spike_pack;

    logic [DATA_W-1:0] v_cur;
    logic [DATA_W-1:0] v_leak;
    logic [SUM_W-1:0]  v_sum;
    logic [DATA_W-1:0] v_next;
    logic              spike;
    logic [WORD_W-1:0] push_word;
    logic              word_due;

    logic [WORD_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]  fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_push;
    logic              fifo_pop;

    assign fifo_full  = (fifo_count == (FIFO_AW + 1)'(FIFO_DEPTH));
    assign fifo_empty = (fifo_count == '0);

    // A word is due every fourth postsyn neuron; it cannot be dropped, so the scan waits.
    assign word_due      = (postsyn_neuron_counter_num[1:0] == 2'd3);
    assign postsyn_stall = word_due && fifo_full;

    lif_scan_counter u_presyn_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .cmd     (presyn_cntl_sig),
        .stall   (1'b0),
        .num     (presyn_neuron_counter_num),
        .done    (presyn_counter_done),
        .advance (presyn_advance)
    );

    lif_scan_counter u_postsyn_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .cmd     (postsyn_cntl_sig),
        .stall   (postsyn_stall),
        .num     (postsyn_neuron_counter_num),
        .done    (postsyn_counter_done),
        .advance (postsyn_advance)
    );

    // Synaptic current: cleared by presyn reset command, bumped on each input-spike index.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            syn_current <= '0;
        end else if (presyn_cntl_sig == CMD_RST) begin
            syn_current <= '0;
        end else if (presyn_advance && is_input_spike(presyn_neuron_counter_num)) begin
            syn_current <= sat_add_current(syn_current, COEF_W'(WEIGHT));
        end
    end

    // Membrane update for the current postsyn index; sum is widened so it cannot wrap.
    always_comb begin
        v_cur = membrane[postsyn_neuron_counter_num];
`ifdef LIF_LEAK_EN
        v_leak = v_cur >> LEAK_SHIFT;
`else
        v_leak = '0;
`endif
        v_sum = {2'b00, v_cur} + {2'b00, syn_current}
              + {{(SUM_W - 2){1'b0}}, postsyn_neuron_counter_num[1:0]}
              - {2'b00, v_leak};
        v_next = sat_membrane(v_sum);
        spike  = (v_next >= DATA_W'(THRESHOLD));
        push_word = spike_pack;
        push_word[postsyn_neuron_counter_num[1:0]] = spike;
    end

    assign fifo_push = postsyn_advance && word_due;
    assign fifo_pop  = dbg_sig_rd_fifo && !fifo_empty;

    // Membrane array: firing neurons return to zero, others keep the integrated value.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < NEURONS; k++) begin
                membrane[k] <= '0;
            end
        end else if (postsyn_advance) begin
            membrane[postsyn_neuron_counter_num] <= spike ? '0 : v_next;
        end
    end

    // Spike word under construction; every bit is rewritten before its word is pushed.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            spike_pack <= '0;
        end else if (postsyn_advance) begin
            spike_pack <= push_word;
        end
    end

    // FIFO storage; emptiness is tracked by the pointers, so the data needs no reset.
    always_ff @(posedge clk_i) begin
        if (fifo_push) begin
            fifo_mem[wr_ptr] <= push_word;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (fifo_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (fifo_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (fifo_push && !fifo_pop) begin
                fifo_count <= fifo_count + 1'b1;
            end else if (fifo_pop && !fifo_push) begin
                fifo_count <= fifo_count - 1'b1;
            end
        end
    end

    assign fifo_output_genfifo_req_o = !fifo_empty;

    // Head word falls through; an empty FIFO presents zero.
    always_comb begin
        fifo_output_genfifo_wdata_bo[0] = fifo_empty ? '0 : fifo_mem[rd_ptr];
    end

endmodule

// File: tb/tb_neuromorphic_design.sv
// Directed bench for neuromorphic_design with a cycle-level reference model
// and a scoreboard queue of expected spike words.
module tb_neuromorphic_design;

    logic       clk_i;
    logic       rst_i;
    logic [2:0] presyn_cntl_sig;
    logic [2:0] postsyn_cntl_sig;
    logic       dbg_sig_rd_fifo;
    logic       fifo_output_genfifo_req_o;
    logic [3:0] fifo_output_genfifo_wdata_bo [0:0];

    int n_checks = 0;
    int n_err    = 0;

    // Reference model state
    int         m_pre_num, m_pre_done, m_cur;
    int         m_post_num, m_post_done;
    int         m_v [256];
    int         m_cnt;
    logic [3:0] m_pack;
    logic [3:0] exp_q [$];

    neuromorphic_design dut (
        .clk_i                        (clk_i),
        .rst_i                        (rst_i),
        .presyn_cntl_sig              (presyn_cntl_sig),
        .postsyn_cntl_sig             (postsyn_cntl_sig),
        .dbg_sig_rd_fifo              (dbg_sig_rd_fifo),
        .fifo_output_genfifo_req_o    (fifo_output_genfifo_req_o),
        .fifo_output_genfifo_wdata_bo (fifo_output_genfifo_wdata_bo)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_i            = 1'b1;
        presyn_cntl_sig  = 3'b000;
        postsyn_cntl_sig = 3'b000;
        dbg_sig_rd_fifo  = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i       = 1'b0;
        m_pre_num   = 0;
        m_pre_done  = 0;
        m_cur       = 0;
        m_post_num  = 0;
        m_post_done = 0;
        for (int k = 0; k < 256; k++) m_v[k] = 0;
        m_cnt  = 0;
        m_pack = 4'h0;
        exp_q.delete();
    endtask

    // One clock cycle: check FIFO outputs, drive commands, advance the model.
    task automatic cycle(input logic [2:0] pc, input logic [2:0] qc, input logic rd);
        int n, v, s, leak;
        logic sp;
        logic do_push, do_pop;
        logic [3:0] word;
        presyn_cntl_sig  = pc;
        postsyn_cntl_sig = qc;
        dbg_sig_rd_fifo  = rd;
        check("req", {31'b0, fifo_output_genfifo_req_o}, {31'b0, (m_cnt != 0)});
        if (m_cnt != 0) check("wdata", {28'b0, fifo_output_genfifo_wdata_bo[0]}, {28'b0, exp_q[0]});
        else            check("wdata_empty", {28'b0, fifo_output_genfifo_wdata_bo[0]}, 32'd0);

        do_push = 1'b0;
        word    = 4'h0;
        // postsyn side, using the current value before this edge
        n = m_post_num;
        if (qc == 3'b011) begin
            m_post_num  = 0;
            m_post_done = 0;
        end else if (qc == 3'b001 && m_post_done == 0 && !((n % 4) == 3 && m_cnt == 64)) begin
            v = m_v[n];
`ifdef LIF_LEAK_EN
            leak = v >> 4;
`else
            leak = 0;
`endif
            s = v + m_cur + (n % 4) - leak;
            if (s > 65535) s = 65535;
            sp = (s >= 1024);
            m_v[n] = sp ? 0 : s;
            m_pack[n % 4] = sp;
            if ((n % 4) == 3) begin
                do_push = 1'b1;
                word    = m_pack;
            end
            if (n == 255) m_post_done = 1;
            else          m_post_num  = n + 1;
        end
        // presyn side
        if (pc == 3'b011) begin
            m_pre_num  = 0;
            m_pre_done = 0;
            m_cur      = 0;
        end else if (pc == 3'b001 && m_pre_done == 0) begin
            if ((m_pre_num % 4) == 0) begin
                m_cur = m_cur + 16;
                if (m_cur > 65535) m_cur = 65535;
            end
            if (m_pre_num == 255) m_pre_done = 1;
            else                  m_pre_num  = m_pre_num + 1;
        end
        // FIFO scoreboard
        do_pop = rd && (m_cnt != 0);
        if (do_pop) begin
            void'(exp_q.pop_front());
            m_cnt--;
        end
        if (do_push) begin
            exp_q.push_back(word);
            m_cnt++;
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_state(input string tag);
        check({tag, "_pre_num"},   {24'b0, dut.presyn_neuron_counter_num},  m_pre_num);
        check({tag, "_pre_done"},  {31'b0, dut.presyn_counter_done},        m_pre_done);
        check({tag, "_cur"},       {16'b0, dut.syn_current},                m_cur);
        check({tag, "_post_num"},  {24'b0, dut.postsyn_neuron_counter_num}, m_post_num);
        check({tag, "_post_done"}, {31'b0, dut.postsyn_counter_done},       m_post_done);
    endtask

    task automatic check_membranes(input string tag);
        for (int k = 0; k < 256; k++) begin
            if (k < 8 || k > 251) check({tag, "_v"}, {16'b0, dut.membrane[k]}, m_v[k]);
        end
    endtask

    initial begin
        // Reset state
        do_reset();
        check("rst_pre_num",  {24'b0, dut.presyn_neuron_counter_num}, 0);
        check("rst_pre_done", {31'b0, dut.presyn_counter_done}, 0);
        check("rst_post_num", {24'b0, dut.postsyn_neuron_counter_num}, 0);
        check("rst_cur",      {16'b0, dut.syn_current}, 0);
        check("rst_req",      {31'b0, fifo_output_genfifo_req_o}, 0);
        check("rst_wdata",    {28'b0, fifo_output_genfifo_wdata_bo[0]}, 0);
        check("rst_v0",       {16'b0, dut.membrane[0]}, 0);

        // Full presyn scan, then extra run cycles must not change anything
        repeat (256) cycle(3'b001, 3'b000, 1'b0);
        check("pre_full_num",  {24'b0, dut.presyn_neuron_counter_num}, 255);
        check("pre_full_done", {31'b0, dut.presyn_counter_done}, 1);
        check("pre_full_cur",  {16'b0, dut.syn_current}, 1024);
        repeat (4) cycle(3'b001, 3'b000, 1'b0);
        check("pre_hold_num", {24'b0, dut.presyn_neuron_counter_num}, 255);
        check("pre_hold_cur", {16'b0, dut.syn_current}, 1024);
        check_state("pre_hold");

        // Postsyn scan with I=1024: every neuron fires
        repeat (4) cycle(3'b000, 3'b001, 1'b0);
        check("first_push_req",   {31'b0, fifo_output_genfifo_req_o}, 1);
        check("first_push_wdata", {28'b0, fifo_output_genfifo_wdata_bo[0]}, 32'hF);
        repeat (252) cycle(3'b000, 3'b001, 1'b0);
        check("post_full_done", {31'b0, dut.postsyn_counter_done}, 1);
        check("post_full_num",  {24'b0, dut.postsyn_neuron_counter_num}, 255);
        check_state("post_full");
        check_membranes("fire");
        repeat (64) cycle(3'b000, 3'b000, 1'b1);
        check("drained_req",   {31'b0, fifo_output_genfifo_req_o}, 0);
        check("drained_wdata", {28'b0, fifo_output_genfifo_wdata_bo[0]}, 0);
        cycle(3'b000, 3'b000, 1'b1);  // pop on empty is ignored

        // Run / pause / reset on presyn
        do_reset();
        repeat (5) cycle(3'b001, 3'b000, 1'b0);
        repeat (3) cycle(3'b010, 3'b000, 1'b0);
        check("pause_num",  {24'b0, dut.presyn_neuron_counter_num}, 5);
        check("pause_done", {31'b0, dut.presyn_counter_done}, 0);
        check("pause_cur",  {16'b0, dut.syn_current}, 32);
        cycle(3'b011, 3'b000, 1'b0);
        check("prerst_num", {24'b0, dut.presyn_neuron_counter_num}, 0);
        check("prerst_cur", {16'b0, dut.syn_current}, 0);
        cycle(3'b001, 3'b000, 1'b0);
        cycle(3'b010, 3'b000, 1'b0);
        cycle(3'b001, 3'b000, 1'b0);
        check("pulse_num", {24'b0, dut.presyn_neuron_counter_num}, 2);
        cycle(3'b101, 3'b000, 1'b0);
        check("cmd1xx_num", {24'b0, dut.presyn_neuron_counter_num}, 2);
        check_state("pulse");

        // Postsyn scans with I=0
        do_reset();
        repeat (256) cycle(3'b000, 3'b001, 1'b0);
        for (int k = 0; k < 8; k++) check("v_scan1", {16'b0, dut.membrane[k]}, k % 4);
        check_membranes("scan1");
        check("scan1_word", {28'b0, fifo_output_genfifo_wdata_bo[0]}, 0);
        repeat (64) cycle(3'b000, 3'b000, 1'b1);
        cycle(3'b000, 3'b011, 1'b0);
        repeat (256) cycle(3'b000, 3'b001, 1'b0);
        for (int k = 0; k < 8; k++) check("v_scan2", {16'b0, dut.membrane[k]}, 2 * (k % 4));
        check("v_scan2_255", {16'b0, dut.membrane[255]}, 6);
        check_membranes("scan2");

        // FIFO now holds 64 words: the next scan stalls at index 3
        cycle(3'b000, 3'b011, 1'b0);
        repeat (8) cycle(3'b000, 3'b001, 1'b0);
        check("stall_num", {24'b0, dut.postsyn_neuron_counter_num}, 3);
        check_state("stall");
        cycle(3'b000, 3'b001, 1'b1);
        check("stall_pop_num", {24'b0, dut.postsyn_neuron_counter_num}, 3);
        cycle(3'b000, 3'b001, 1'b0);
        check("unstall_num", {24'b0, dut.postsyn_neuron_counter_num}, 4);
        check("unstall_req", {31'b0, fifo_output_genfifo_req_o}, 1);
        check_state("unstall");
        repeat (64) cycle(3'b000, 3'b000, 1'b1);
        check("final_req", {31'b0, fifo_output_genfifo_req_o}, 0);
        check_membranes("final");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
